// File: rtl/frequency_calc.sv
// Gate-window frequency meter: counts clk_test rising edges per gate, shows the count on a 4-digit mux display.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zeros above the units digit.
module frequency_calc #(
    parameter int unsigned GATE_CYCLES = 100000,
    parameter int unsigned SCAN_CYCLES = 100000,
    parameter int unsigned MAX_COUNT   = 9999
) (
    input  logic       clk_stand,
    input  logic       rst_n,
    input  logic       clk_test,
    output logic [3:0] dig,
    output logic [6:0] seg
);

    localparam int unsigned GW = $clog2(GATE_CYCLES + 1);
    localparam int unsigned SW = $clog2(SCAN_CYCLES + 1);
    localparam int unsigned CW = 14;

    localparam logic [6:0] SEG_ZERO  = 7'b1000000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    logic          sync1_q, sync2_q, sync3_q;
    logic [GW-1:0] gate_q, gate_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] result_q, result_d;
    logic [SW-1:0] scan_q, scan_d;
    logic [1:0]    idx_q, idx_d;
    logic [3:0]    dig_d;
    logic [6:0]    seg_d;
    logic          edge_pulse_c;
    logic          gate_end_c;
    logic [CW:0]   sum_c;
    logic [15:0]   bcd_c;
    logic [3:0]    digit_c;
    logic          blank_c;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    seg_of = 7'b1000000;
            4'd1:    seg_of = 7'b1111001;
            4'd2:    seg_of = 7'b0100100;
            4'd3:    seg_of = 7'b0110000;
            4'd4:    seg_of = 7'b0011001;
            4'd5:    seg_of = 7'b0010010;
            4'd6:    seg_of = 7'b0000010;
            4'd7:    seg_of = 7'b1111000;
            4'd8:    seg_of = 7'b0000000;
            4'd9:    seg_of = 7'b0010000;
            default: seg_of = SEG_BLANK;
        endcase
    endfunction

    assign edge_pulse_c = sync2_q & ~sync3_q;
    assign gate_end_c   = (gate_q == GW'(GATE_CYCLES - 1));

    // Gate timer, saturating edge counter and result latch; the edge in the wrap cycle goes to the result.
    always_comb begin
        gate_d   = gate_q + GW'(1);
        cnt_d    = cnt_q;
        result_d = result_q;
        sum_c    = {1'b0, cnt_q} + (CW + 1)'(edge_pulse_c);
        if (gate_end_c) begin
            gate_d   = '0;
            cnt_d    = '0;
            result_d = (sum_c > (CW + 1)'(MAX_COUNT)) ? CW'(MAX_COUNT) : sum_c[CW-1:0];
        end else if (edge_pulse_c && (cnt_q < CW'(MAX_COUNT))) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Double-dabble of the result into four BCD digits.
    always_comb begin
        bcd_c = '0;
        for (int i = CW - 1; i >= 0; i--) begin
            for (int d = 0; d < 4; d++) begin
                if (bcd_c[4*d +: 4] >= 4'd5) bcd_c[4*d +: 4] = bcd_c[4*d +: 4] + 4'd3;
            end
            bcd_c = {bcd_c[14:0], result_q[i]};
        end
    end

    always_comb begin
        scan_d = scan_q + SW'(1);
        idx_d  = idx_q;
        if (scan_q == SW'(SCAN_CYCLES - 1)) begin
            scan_d = '0;
            idx_d  = idx_q + 2'd1;
        end
        digit_c = bcd_c[4*idx_d +: 4];
`ifdef LEADING_ZERO_BLANK_EN
        case (idx_d)
            2'd1:    blank_c = (bcd_c[15:4] == 12'd0);
            2'd2:    blank_c = (bcd_c[15:8] == 8'd0);
            2'd3:    blank_c = (bcd_c[15:12] == 4'd0);
            default: blank_c = 1'b0;
        endcase
`else
        blank_c = 1'b0;
`endif
        dig_d = ~(4'b0001 << idx_d);
        seg_d = blank_c ? SEG_BLANK : seg_of(digit_c);
    end

    always_ff @(posedge clk_stand) begin
        if (rst_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            sync3_q  <= 1'b0;
            gate_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            scan_q   <= '0;
            idx_q    <= '0;
            dig      <= 4'b1110;
            seg      <= SEG_ZERO;
        end else begin
            sync1_q  <= clk_test;
            sync2_q  <= sync1_q;
            sync3_q  <= sync2_q;
            gate_q   <= gate_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            scan_q   <= scan_d;
            idx_q    <= idx_d;
            dig      <= dig_d;
            seg      <= seg_d;
        end
    end

endmodule

// File: tb/tb_frequency_calc.sv
// Directed bench for frequency_calc: reset state, scan order, measured counts, mid-gate reset, saturation.
module tb_frequency_calc;

    localparam int unsigned GATE     = 1000;
    localparam int unsigned SAT_GATE = 65000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       rst_s = 1'b1;
    logic       clk_test = 1'b0;
    logic       clk_test_s = 1'b0;
    logic [3:0] dig, dig_s;
    logic [6:0] seg, seg_s;
    int         half_ns = 40;
    int         cyc = 0;
    int         total = 0;
    int         bad = 0;
    int         rel;

    frequency_calc #(.GATE_CYCLES(GATE), .SCAN_CYCLES(4)) u_dut (
        .clk_stand(clk), .rst_n(rst_n), .clk_test(clk_test), .dig(dig), .seg(seg)
    );

    frequency_calc #(.GATE_CYCLES(SAT_GATE), .SCAN_CYCLES(4)) u_sat (
        .clk_stand(clk), .rst_n(rst_s), .clk_test(clk_test_s), .dig(dig_s), .seg(seg_s)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Test signals toggle 3 ns off the clock grid so edge timing is deterministic.
    initial begin
        #3;
        forever #(half_ns) clk_test = ~clk_test;
    end
    initial begin
        #3;
        forever #30 clk_test_s = ~clk_test_s;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] exp_seg(input int value, input int k);
        int p = 1;
        int d;
        for (int i = 0; i < k; i++) p = p * 10;
        d = (value / p) % 10;
`ifdef LEADING_ZERO_BLANK_EN
        if (k > 0 && value < p) return 7'b1111111;
`endif
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            default: return 7'b0010000;
        endcase
    endfunction

    task automatic wait_until(input int c);
        while (cyc < c) @(posedge clk);
    endtask

    // Sample one full scan sweep and compare every digit against the expected value.
    task automatic check_display(input string tag, input bit sel, input int value);
        logic [3:0][6:0] s;
        logic [3:0] d;
        logic [6:0] g;
        s = 'x;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            d = sel ? dig_s : dig;
            g = sel ? seg_s : seg;
            case (d)
                4'b1110: s[0] = g;
                4'b1101: s[1] = g;
                4'b1011: s[2] = g;
                4'b0111: s[3] = g;
                default: ;
            endcase
        end
        for (int k = 0; k < 4; k++)
            check($sformatf("%s_d%0d", tag, k), 32'(s[k]), 32'(exp_seg(value, k)));
    endtask

    initial begin
        repeat (10) @(posedge clk);
        #1;
        check("rst_dig", 32'(dig), 32'h0e);
        check("rst_seg", 32'(seg), 32'(7'b1000000));

        @(negedge clk);
        rst_n = 1'b0;
        rst_s = 1'b0;
        rel = cyc;
        // Index advances on every 4th clock after release.
        for (int n = 1; n <= 16; n++) begin
            logic [3:0] ed;
            @(posedge clk); #1;
            ed = ~(4'b0001 << ((n / 4) % 4));
            check($sformatf("scan_dig_n%0d", n), 32'(dig), 32'(ed));
            check($sformatf("scan_seg_n%0d", n), 32'(seg), 32'(exp_seg(0, (n / 4) % 4)));
        end

        wait_until(rel + 500);
        check_display("gate1", 1'b0, 0);
        wait_until(rel + 2100);
        check_display("f125", 1'b0, 125);

        wait_until(rel + 2500);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        rel = cyc;
        #1;
        check("midrst_dig", 32'(dig), 32'h0e);
        check("midrst_seg", 32'(seg), 32'(7'b1000000));
        check_display("midrst", 1'b0, 0);
        wait_until(rel + 2100);
        check_display("after_rst", 1'b0, 125);

        wait_until(rel + 2300);
        half_ns = 50;
        wait_until(rel + 4100);
        check_display("f100", 1'b0, 100);

        wait_until(SAT_GATE + 300);
        check_display("sat", 1'b1, 9999);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
